// File: rtl/serial_link_cfg_trainer.sv
// serial_link_cfg_trainer: register-bus initiator that sweeps the serial link
// RX sampling delay, finds the longest contiguous locked window and programs
// its centre tap. One outstanding cfg transaction at a time.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// Idle     | waiting for start_i
// WrMask   | write train mask to TrainingMask, await response
// WrDly    | write current tap to Delay, await response
// Settle   | let the receiver settle on the new tap (down-counter)
// RdStat   | read Status, capture lock bit
// Eval     | update run/best window, pick next tap or finish sweep
// WrBest   | write chosen centre tap to Delay
// WrUnmask | write 0 to TrainingMask
// Done     | done_o pulse, then back to Idle
// Err      | bus error seen; report and finish without more requests
module serial_link_cfg_trainer #(
  parameter int DelayWidth   = 5,
  parameter int SettleCycles = 16,
  parameter int LockBit      = 0,
  parameter int TrainMaskW   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [TrainMaskW-1:0] train_mask_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [31:0]           req_addr_o,
  output logic                  req_write_o,
  output logic [31:0]           req_wdata_o,
  input  logic                  rsp_valid_i,
  input  logic [31:0]           rsp_rdata_i,
  input  logic                  rsp_error_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic                  err_o,
  output logic [DelayWidth-1:0] best_delay_o,
  output logic [DelayWidth:0]   window_len_o
);

  typedef enum logic [31:0] {
    AddrStatus       = 32'h0000_0000,
    AddrTrainingMask = 32'h0000_0008,
    AddrDelay        = 32'h0000_0010
  } serial_cfg_addr_e;

  typedef enum logic [3:0] {
    Idle, WrMask, WrDly, Settle, RdStat, Eval, WrBest, WrUnmask, Done, Err
  } state_e;

  localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [DelayWidth-1:0] TapMax = '1;

  state_e                state;
  logic [DelayWidth-1:0] tap;
  logic [DelayWidth-1:0] runStart;
  logic [DelayWidth-1:0] bestStart;
  logic [DelayWidth-1:0] centre;
  logic [DelayWidth:0]   runLen;
  logic [DelayWidth:0]   bestLen;
  logic [CntW-1:0]       settleCnt;
  logic                  passReg;
  logic                  waitRsp;

  logic                  accept;
  logic                  rspNow;
  logic [DelayWidth:0]   newRun;
  logic                  newBest;
  logic [DelayWidth:0]   nextBestLen;
  logic [DelayWidth-1:0] nextBestStart;
  logic [DelayWidth-1:0] nextCentre;
  logic                  unusedRdata;

  // Only the lock bit of the status word matters.
  assign unusedRdata = ^rsp_rdata_i;

  // Handshake qualifiers and the window update applied in Eval.
  always_comb begin
    accept        = req_valid_o & req_ready_i;
    rspNow        = rsp_valid_i & (waitRsp | accept);
    newRun        = passReg ? runLen + 1'b1 : '0;
    newBest       = newRun > bestLen;
    nextBestLen   = newBest ? newRun : bestLen;
    nextBestStart = bestStart;
    if (newBest) nextBestStart = (runLen == '0) ? tap : runStart;
    nextCentre    = '0;
    if (nextBestLen != '0)
      nextCentre = nextBestStart + DelayWidth'((nextBestLen - 1'b1) >> 1);
  end

  // Training sequencer; a response with rsp_error_i from any bus state goes to Err.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= Idle;
      req_valid_o  <= 1'b0;
      req_addr_o   <= '0;
      req_write_o  <= 1'b0;
      req_wdata_o  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      fail_o       <= 1'b0;
      err_o        <= 1'b0;
      best_delay_o <= '0;
      window_len_o <= '0;
      tap          <= '0;
      runStart     <= '0;
      bestStart    <= '0;
      centre       <= '0;
      runLen       <= '0;
      bestLen      <= '0;
      settleCnt    <= '0;
      passReg      <= 1'b0;
      waitRsp      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        req_valid_o <= 1'b0;
        waitRsp     <= ~rsp_valid_i;
      end else if (waitRsp && rsp_valid_i) begin
        waitRsp <= 1'b0;
      end

      case (state)
        Idle: if (start_i) begin
          busy_o      <= 1'b1;
          fail_o      <= 1'b0;
          err_o       <= 1'b0;
          tap         <= '0;
          runStart    <= '0;
          bestStart   <= '0;
          runLen      <= '0;
          bestLen     <= '0;
          req_valid_o <= 1'b1;
          req_addr_o  <= AddrTrainingMask;
          req_write_o <= 1'b1;
          req_wdata_o <= 32'(train_mask_i);
          state       <= WrMask;
        end
        WrMask: if (rspNow) begin
          if (rsp_error_i) state <= Err;
          else begin
            req_valid_o <= 1'b1;
            req_addr_o  <= AddrDelay;
            req_write_o <= 1'b1;
            req_wdata_o <= 32'(tap);
            state       <= WrDly;
          end
        end
        WrDly: if (rspNow) begin
          if (rsp_error_i) state <= Err;
          else begin
            settleCnt <= CntW'(SettleCycles - 1);
            state     <= Settle;
          end
        end
        Settle: begin
          if (settleCnt == '0) begin
            req_valid_o <= 1'b1;
            req_addr_o  <= AddrStatus;
            req_write_o <= 1'b0;
            req_wdata_o <= '0;
            state       <= RdStat;
          end else begin
            settleCnt <= settleCnt - 1'b1;
          end
        end
        RdStat: if (rspNow) begin
          if (rsp_error_i) state <= Err;
          else begin
            passReg <= rsp_rdata_i[LockBit];
            state   <= Eval;
          end
        end
        Eval: begin
          runLen    <= newRun;
          if (passReg && runLen == '0) runStart <= tap;
          bestLen   <= nextBestLen;
          bestStart <= nextBestStart;
          req_valid_o <= 1'b1;
          req_addr_o  <= AddrDelay;
          req_write_o <= 1'b1;
          if (tap == TapMax) begin
            centre      <= nextCentre;
            req_wdata_o <= 32'(nextCentre);
            state       <= WrBest;
          end else begin
            tap         <= tap + 1'b1;
            req_wdata_o <= 32'(tap + 1'b1);
            state       <= WrDly;
          end
        end
        WrBest: if (rspNow) begin
          if (rsp_error_i) state <= Err;
          else begin
            req_valid_o <= 1'b1;
            req_addr_o  <= AddrTrainingMask;
            req_write_o <= 1'b1;
            req_wdata_o <= '0;
            state       <= WrUnmask;
          end
        end
        WrUnmask: if (rspNow) begin
          if (rsp_error_i) state <= Err;
          else begin
            done_o       <= 1'b1;
            busy_o       <= 1'b0;
            fail_o       <= (bestLen == '0);
            best_delay_o <= centre;
            window_len_o <= bestLen;
            state        <= Done;
          end
        end
        Done: state <= Idle;
        Err: begin
          done_o       <= 1'b1;
          busy_o       <= 1'b0;
          err_o        <= 1'b1;
          fail_o       <= 1'b1;
          best_delay_o <= '0;
          window_len_o <= '0;
          state        <= Done;
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_link_cfg_trainer.sv
// Directed bench for serial_link_cfg_trainer with a small cfg-space responder
// (lock map per tap, optional request stall, optional same-cycle response,
// optional error on the Nth Status read).
module tb_serial_link_cfg_trainer;
  localparam int DW = 3;
  localparam int SC = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [7:0]    train_mask_i;
  logic          req_valid_o;
  logic          req_ready_i;
  logic [31:0]   req_addr_o;
  logic          req_write_o;
  logic [31:0]   req_wdata_o;
  logic          rsp_valid_i;
  logic [31:0]   rsp_rdata_i;
  logic          rsp_error_i;
  logic          busy_o;
  logic          done_o;
  logic          fail_o;
  logic          err_o;
  logic [DW-1:0] best_delay_o;
  logic [DW:0]   window_len_o;

  serial_link_cfg_trainer #(
    .DelayWidth(DW), .SettleCycles(SC), .LockBit(0), .TrainMaskW(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .train_mask_i(train_mask_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .req_write_o(req_write_o), .req_wdata_o(req_wdata_o), .rsp_valid_i(rsp_valid_i),
    .rsp_rdata_i(rsp_rdata_i), .rsp_error_i(rsp_error_i), .busy_o(busy_o),
    .done_o(done_o), .fail_o(fail_o), .err_o(err_o), .best_delay_o(best_delay_o),
    .window_len_o(window_len_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int fails  = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // responder configuration and log
  logic [7:0]    lockMap = 8'h00;
  int            stallCycles = 0;
  int            stall = 0;
  bit            sameCycle = 1'b0;
  int            errOnRead = 0;
  int            statusReads = 0;
  logic [DW-1:0] curDelay = '0;
  logic [31:0]   wrAddr[$];
  logic [31:0]   wrData[$];
  int            reqCount = 0;
  int            doneCnt = 0;
  int            stableErr = 0;
  bit            pend = 1'b0;
  logic [31:0]   pendData;
  logic          pendErr;
  bit            seen = 1'b0;
  logic [31:0]   snapAddr, snapData;
  logic          snapWr;

  // Responder: decides ready for the coming edge at each negedge; response
  // arrives in the same cycle as ready (sameCycle) or one cycle later.
  initial begin
    req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_rdata_i = '0; rsp_error_i = 1'b0;
    forever begin
      logic [31:0] rd;
      logic        re;
      @(negedge clk_i);
      if (done_o) doneCnt++;
      rsp_valid_i = 1'b0; rsp_error_i = 1'b0; rsp_rdata_i = '0; req_ready_i = 1'b0;
      if (rst_i) begin
        pend = 1'b0; seen = 1'b0; stall = stallCycles;
        continue;
      end
      if (pend) begin
        rsp_valid_i = 1'b1; rsp_rdata_i = pendData; rsp_error_i = pendErr; pend = 1'b0;
      end
      if (req_valid_o) begin
        if (!seen) begin
          snapAddr = req_addr_o; snapData = req_wdata_o; snapWr = req_write_o; seen = 1'b1;
        end else if (snapAddr !== req_addr_o || snapData !== req_wdata_o || snapWr !== req_write_o) begin
          stableErr++;
        end
        if (stall > 0) stall--;
        else begin
          req_ready_i = 1'b1; reqCount++; seen = 1'b0; stall = stallCycles;
          rd = '0; re = 1'b0;
          if (req_write_o) begin
            wrAddr.push_back(req_addr_o); wrData.push_back(req_wdata_o);
            if (req_addr_o == 32'h10) curDelay = req_wdata_o[DW-1:0];
          end else begin
            statusReads++;
            rd = {31'd0, lockMap[curDelay]};
            re = (statusReads == errOnRead);
          end
          if (sameCycle) begin
            rsp_valid_i = 1'b1; rsp_rdata_i = rd; rsp_error_i = re;
          end else begin
            pend = 1'b1; pendData = rd; pendErr = re;
          end
        end
      end
    end
  end

  task automatic setup(input logic [7:0] lock, input int stallC, input bit same, input int errIdx);
    lockMap = lock; stallCycles = stallC; stall = stallC; sameCycle = same; errOnRead = errIdx;
    statusReads = 0; wrAddr.delete(); wrData.delete(); reqCount = 0; doneCnt = 0; stableErr = 0;
  endtask

  task automatic pulseStart(input logic [7:0] mask);
    @(negedge clk_i); start_i = 1'b1; train_mask_i = mask;
    @(negedge clk_i); start_i = 1'b0;
  endtask

  task automatic waitDone();
    bit got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_i);
      if (done_o) begin got = 1'b1; break; end
    end
    if (!got) checkVal("done_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge clk_i);
  endtask

  task automatic checkResult(input string tag, input int best, input int len, input bit f, input bit e);
    checkVal({tag, "_best"}, 32'(best_delay_o), 32'(best));
    checkVal({tag, "_len"},  32'(window_len_o), 32'(len));
    checkVal({tag, "_fail"}, 32'(fail_o), 32'(f));
    checkVal({tag, "_err"},  32'(err_o), 32'(e));
    checkVal({tag, "_done_pulses"}, doneCnt, 32'd1);
    checkVal({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; train_mask_i = '0;
    repeat (3) @(negedge clk_i);
    checkVal("rst_req_valid", 32'(req_valid_o), 32'd0);
    checkVal("rst_busy", 32'(busy_o), 32'd0);
    checkVal("rst_done", 32'(done_o), 32'd0);
    checkVal("rst_fail_err", 32'({fail_o, err_o}), 32'd0);
    rst_i = 1'b0;

    // 1: lock taps 2..5 -> centre 3, window 4, full write sequence
    setup(8'h3C, 0, 1'b0, 0);
    pulseStart(8'hA5);
    checkVal("t1_busy_running", 32'(busy_o), 32'd1);
    waitDone();
    checkVal("t1_writes", wrAddr.size(), 32'd11);
    if (wrAddr.size() == 11) begin
      checkVal("t1_w0_addr", wrAddr[0], 32'h8);
      checkVal("t1_w0_data", wrData[0], 32'hA5);
      for (int k = 0; k < 8; k++) begin
        checkVal("t1_sweep_addr", wrAddr[k+1], 32'h10);
        checkVal("t1_sweep_tap", wrData[k+1], 32'(k));
      end
      checkVal("t1_best_addr", wrAddr[9], 32'h10);
      checkVal("t1_best_data", wrData[9], 32'd3);
      checkVal("t1_unmask_addr", wrAddr[10], 32'h8);
      checkVal("t1_unmask_data", wrData[10], 32'd0);
    end
    checkVal("t1_reads", statusReads, 32'd8);
    checkResult("t1", 3, 4, 1'b0, 1'b0);

    // 2a: windows {1,2} and {4,5,6} -> longer one wins
    setup(8'h76, 0, 1'b0, 0);
    pulseStart(8'h01);
    waitDone();
    checkResult("t2a", 5, 3, 1'b0, 1'b0);

    // 2b: equal windows {0,1},{5,6}, same-cycle responses -> first wins
    setup(8'h63, 0, 1'b1, 0);
    pulseStart(8'h02);
    waitDone();
    checkResult("t2b", 0, 2, 1'b0, 1'b0);

    // 3: nothing locks
    setup(8'h00, 0, 1'b0, 0);
    pulseStart(8'hFF);
    waitDone();
    checkResult("t3", 0, 0, 1'b1, 1'b0);
    if (wrAddr.size() == 11) begin
      checkVal("t3_final_delay", wrData[9], 32'd0);
      checkVal("t3_unmask_addr", wrAddr[10], 32'h8);
      checkVal("t3_unmask_data", wrData[10], 32'd0);
    end else checkVal("t3_writes", wrAddr.size(), 32'd11);

    // 4: every tap locks -> full-width window, no wrap
    setup(8'hFF, 0, 1'b0, 0);
    pulseStart(8'h11);
    waitDone();
    checkResult("t4", 3, 8, 1'b0, 1'b0);

    // 5: error on third Status read
    setup(8'hFF, 0, 1'b0, 3);
    pulseStart(8'h22);
    waitDone();
    checkResult("t5", 0, 0, 1'b1, 1'b1);
    checkVal("t5_req_count", reqCount, 32'd7);
    repeat (20) @(negedge clk_i);
    checkVal("t5_req_count_after", reqCount, 32'd7);

    // 6a: 10-cycle ready stall, stray start mid-sweep
    setup(8'h3C, 10, 1'b0, 0);
    pulseStart(8'hA5);
    repeat (60) @(negedge clk_i);
    pulseStart(8'h33);
    waitDone();
    repeat (30) @(negedge clk_i);
    checkResult("t6a", 3, 4, 1'b0, 1'b0);
    checkVal("t6a_stable", stableErr, 32'd0);
    checkVal("t6a_writes", wrAddr.size(), 32'd11);
    checkVal("t6a_mask", wrData[0], 32'hA5);

    // 6b: reset while settling, then a fresh run
    setup(8'h3C, 0, 1'b0, 0);
    pulseStart(8'h5A);
    for (int i = 0; i < 200 && wrAddr.size() < 2; i++) @(negedge clk_i);
    checkVal("t6b_reached_dly", 32'(wrAddr.size() >= 2), 32'd1);
    repeat (3) @(negedge clk_i);
    checkVal("t6b_pre_rst_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkVal("t6b_rst_req_valid", 32'(req_valid_o), 32'd0);
    checkVal("t6b_rst_busy", 32'(busy_o), 32'd0);
    checkVal("t6b_rst_flags", 32'({done_o, fail_o, err_o}), 32'd0);
    checkVal("t6b_rst_best", 32'(best_delay_o), 32'd0);
    checkVal("t6b_rst_len", 32'(window_len_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    setup(8'h3C, 0, 1'b0, 0);
    pulseStart(8'h5A);
    waitDone();
    checkVal("t6b_first_addr", wrAddr.size() > 0 ? wrAddr[0] : 32'hFFFF_FFFF, 32'h8);
    checkVal("t6b_first_data", wrData.size() > 0 ? wrData[0] : 32'hFFFF_FFFF, 32'h5A);
    checkResult("t6b", 3, 4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
